// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative cache.
//   cache_state_t : controller FSM state encoding
//   clog2_min1    : index width helper that never returns 0 (for 1-way/1-set cases)
//   word_sel_w    : width of the word-select field inside a line
//   word_sel_lsb  : bit position of the word-select field inside a byte address
package cache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_COMPARE   = 3'd1,
    ST_WRITEBACK = 3'd2,
    ST_ALLOCATE  = 3'd3,
    ST_RESPOND   = 3'd4
  } cache_state_t;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned WORD_W = 32;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned word_sel_w(input int unsigned line_size);
    return $clog2(line_size) - 2;
  endfunction

  function automatic int unsigned word_sel_lsb();
    return 2;
  endfunction

endpackage

// File: rtl/cache_lru.sv
// Per-set LRU age tracker.
//   clk, reset         : clock, asynchronous active-low reset (all ages -> 0)
//   upd_en/set/way     : mark way as most recently used in the given set
//   vic_set / vic_way  : combinational victim (oldest way, lowest index on ties)
module cache_lru
  import cache_pkg::*;
#(
  parameter int NUM_SETS = 16,
  parameter int NUM_WAYS = 2,
  localparam int SET_W = clog2_min1(NUM_SETS),
  localparam int WAY_W = clog2_min1(NUM_WAYS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             upd_en,
  input  logic [SET_W-1:0] upd_set,
  input  logic [WAY_W-1:0] upd_way,
  input  logic [SET_W-1:0] vic_set,
  output logic [WAY_W-1:0] vic_way
);

  localparam int AGE_W = WAY_W;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  logic [NUM_SETS-1:0][NUM_WAYS-1:0][AGE_W-1:0] age_q;
  logic [AGE_W-1:0] best_age;

  // After reset every way has age 0, so ties are common; ways whose age is not
  // greater than the accessed way's age are aged (saturating), which lets a
  // freshly touched set still order its ways correctly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      age_q <= '0;
    end else if (upd_en) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (w == int'(upd_way)) begin
          age_q[upd_set][w] <= '0;
        end else if ((age_q[upd_set][w] <= age_q[upd_set][upd_way]) &&
                     (age_q[upd_set][w] != AGE_MAX)) begin
          age_q[upd_set][w] <= age_q[upd_set][w] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    vic_way  = '0;
    best_age = age_q[vic_set][0];
    for (int w = 1; w < NUM_WAYS; w++) begin
      if (age_q[vic_set][w] > best_age) begin
        best_age = age_q[vic_set][w];
        vic_way  = WAY_W'(w);
      end
    end
  end

endmodule

// File: rtl/set_assoc_cache.sv
// Write-back, write-allocate set-associative cache with one outstanding request.
//   clk, reset              : clock, asynchronous active-low reset
//   is_input_valid, addr,
//   mem_read, mem_write, din: CPU request (accepted while is_ready=1)
//   is_ready                : controller idle
//   is_output_valid, dout,
//   is_hit                  : one-cycle completion pulse, read data, first-lookup hit
//   mem_is_input_valid,
//   mem_addr, mem_read_o,
//   mem_write_o, mem_din    : backing-memory request (only while mem_ready=1)
//   mem_is_output_valid,
//   mem_dout, mem_ready     : backing-memory refill data and flow control
module set_assoc_cache
  import cache_pkg::*;
#(
  parameter int LINE_SIZE = 16,
  parameter int NUM_SETS  = 16,
  parameter int NUM_WAYS  = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   is_input_valid,
  input  logic [31:0]            addr,
  input  logic                   mem_read,
  input  logic                   mem_write,
  input  logic [31:0]            din,
  output logic                   is_ready,
  output logic                   is_output_valid,
  output logic [31:0]            dout,
  output logic                   is_hit,
  output logic                   mem_is_input_valid,
  output logic [31:0]            mem_addr,
  output logic                   mem_read_o,
  output logic                   mem_write_o,
  output logic [LINE_SIZE*8-1:0] mem_din,
  input  logic                   mem_is_output_valid,
  input  logic [LINE_SIZE*8-1:0] mem_dout,
  input  logic                   mem_ready
);

  localparam int OFF_W  = $clog2(LINE_SIZE);
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
  localparam int WAY_W  = clog2_min1(NUM_WAYS);
  localparam int WSEL_W = word_sel_w(LINE_SIZE);
  localparam int WSEL_L = word_sel_lsb();
  localparam int LINE_W = LINE_SIZE * 8;

  cache_state_t state, state_next;

  // Storage: tags and lines are plain data, valid/dirty are control
  logic [TAG_W-1:0]  tag_q  [NUM_WAYS][NUM_SETS];
  logic [LINE_W-1:0] line_q [NUM_WAYS][NUM_SETS];
  logic [NUM_WAYS-1:0][NUM_SETS-1:0] valid_q, dirty_q;

  // Latched request (byte-lane bits are dropped)
  logic [31:2]       req_addr;
  logic [31:0]       req_din;
  logic              req_wr;
  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [WSEL_W-1:0] req_wsel;
  logic              addr_lsb_unused;

  logic              accept, first_q, sent_q, miv_prev_q, refill;
  logic              hit, inv_found, vic_dirty;
  logic [WAY_W-1:0]  hit_way, inv_way, lru_vic, vic_sel, victim_q;
  logic [31:0]       rd_word;

  assign addr_lsb_unused = ^addr[1:0];
  assign req_idx  = req_addr[OFF_W +: IDX_W];
  assign req_tag  = req_addr[31 -: TAG_W];
  assign req_wsel = req_addr[WSEL_L +: WSEL_W];

  assign accept = (state == ST_IDLE) && is_input_valid && (mem_read ^ mem_write);
  // Refill is only taken after this ALLOCATE issued its read, so a response
  // belonging to a transaction abandoned by reset is dropped.
  assign refill = (state == ST_ALLOCATE) && sent_q && mem_is_output_valid;

  // Tag lookup and first-invalid-way search for the latched set
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (!hit && valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!inv_found && !valid_q[w][req_idx]) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  assign vic_sel   = inv_found ? inv_way : lru_vic;
  assign vic_dirty = valid_q[vic_sel][req_idx] && dirty_q[vic_sel][req_idx];
  assign rd_word   = line_q[hit_way][req_idx][req_wsel*32 +: 32];

  cache_lru #(
    .NUM_SETS (NUM_SETS),
    .NUM_WAYS (NUM_WAYS)
  ) u_lru (
    .clk     (clk),
    .reset   (reset),
    .upd_en  ((state == ST_COMPARE) && hit),
    .upd_set (req_idx),
    .upd_way (hit_way),
    .vic_set (req_idx),
    .vic_way (lru_vic)
  );

  // FSM state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // FSM next state
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:      if (accept) state_next = ST_COMPARE;
      ST_COMPARE: begin
        if (hit)            state_next = ST_RESPOND;
        else if (vic_dirty) state_next = ST_WRITEBACK;
        else                state_next = ST_ALLOCATE;
      end
      ST_WRITEBACK: if (mem_is_input_valid) state_next = ST_ALLOCATE;
      ST_ALLOCATE:  if (refill) state_next = ST_COMPARE;
      ST_RESPOND:   state_next = ST_IDLE;
      default:      state_next = ST_IDLE;
    endcase
  end

  // FSM outputs. The memory strobe is gated by mem_ready directly and by the
  // previous cycle's strobe, so it can never be back-to-back.
  always_comb begin
    is_ready           = (state == ST_IDLE);
    is_output_valid    = (state == ST_RESPOND);
    mem_is_input_valid = ((state == ST_WRITEBACK) || ((state == ST_ALLOCATE) && !sent_q)) &&
                         mem_ready && !miv_prev_q;
    mem_write_o        = mem_is_input_valid && (state == ST_WRITEBACK);
    mem_read_o         = mem_is_input_valid && (state == ST_ALLOCATE);
    mem_addr           = {req_tag, req_idx, {OFF_W{1'b0}}};
    if (state == ST_WRITEBACK) mem_addr = {tag_q[victim_q][req_idx], req_idx, {OFF_W{1'b0}}};
    mem_din            = line_q[victim_q][req_idx];
  end

  // Control and result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      first_q    <= 1'b0;
      sent_q     <= 1'b0;
      miv_prev_q <= 1'b0;
      dout       <= '0;
      is_hit     <= 1'b0;
      valid_q    <= '0;
      dirty_q    <= '0;
    end else begin
      miv_prev_q <= mem_is_input_valid;
      if (state == ST_ALLOCATE) begin
        if (mem_is_input_valid) sent_q <= 1'b1;
      end else begin
        sent_q <= 1'b0;
      end
      if (accept)                    first_q <= 1'b1;
      else if (state == ST_COMPARE)  first_q <= 1'b0;
      if ((state == ST_COMPARE) && hit) begin
        // Only the first lookup of a request can report a hit
        is_hit <= first_q;
        if (!req_wr) dout <= rd_word;
        if (req_wr)  dirty_q[hit_way][req_idx] <= 1'b1;
      end
      if ((state == ST_WRITEBACK) && mem_is_input_valid) dirty_q[victim_q][req_idx] <= 1'b0;
      if (refill) begin
        valid_q[victim_q][req_idx] <= 1'b1;
        dirty_q[victim_q][req_idx] <= 1'b0;
      end
    end
  end

  // Request capture, victim choice and line/tag storage (no reset needed)
  always_ff @(posedge clk) begin
    if (accept) begin
      req_addr <= addr[31:2];
      req_din  <= din;
      req_wr   <= mem_write;
    end
    if ((state == ST_COMPARE) && !hit) victim_q <= vic_sel;
    if ((state == ST_COMPARE) && hit && req_wr) line_q[hit_way][req_idx][req_wsel*32 +: 32] <= req_din;
    if (refill) begin
      line_q[victim_q][req_idx] <= mem_dout;
      tag_q[victim_q][req_idx]  <= req_tag;
    end
  end

endmodule

// File: tb/tb_set_assoc_cache.sv
module tb_set_assoc_cache;

  logic         clk = 1'b0;
  logic         reset;
  logic         is_input_valid;
  logic [31:0]  addr;
  logic         mem_read, mem_write;
  logic [31:0]  din;
  logic         is_ready, is_output_valid;
  logic [31:0]  dout;
  logic         is_hit;
  logic         mem_is_input_valid;
  logic [31:0]  mem_addr;
  logic         mem_read_o, mem_write_o;
  logic [127:0] mem_din;
  logic         mem_is_output_valid;
  logic [127:0] mem_dout;
  logic         mem_ready;

  set_assoc_cache #(.LINE_SIZE(16), .NUM_SETS(16), .NUM_WAYS(2)) dut (
    .clk                 (clk),
    .reset               (reset),
    .is_input_valid      (is_input_valid),
    .addr                (addr),
    .mem_read            (mem_read),
    .mem_write           (mem_write),
    .din                 (din),
    .is_ready            (is_ready),
    .is_output_valid     (is_output_valid),
    .dout                (dout),
    .is_hit              (is_hit),
    .mem_is_input_valid  (mem_is_input_valid),
    .mem_addr            (mem_addr),
    .mem_read_o          (mem_read_o),
    .mem_write_o         (mem_write_o),
    .mem_din             (mem_din),
    .mem_is_output_valid (mem_is_output_valid),
    .mem_dout            (mem_dout),
    .mem_ready           (mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        chk_dout;
    logic [31:0] dout;
    logic        hit;
  } resp_t;

  typedef struct {
    logic         wr;
    logic [31:0]  a;
    logic [127:0] d;
  } mreq_t;

  resp_t resp_q[$];
  mreq_t mreq_q[$];
  logic [127:0] mem_model [logic [31:0]];

  int npass = 0;
  int ntot  = 0;
  int mcyc  = 0;
  int last_resp_cyc = 0;
  int acc_cyc = 0;
  int mem_req_cnt = 0;
  logic prev_miv = 1'b0;
  logic rd_pend = 1'b0;
  int   rd_cnt = 0;
  logic [31:0] rd_addr = '0;
  logic stray_req = 1'b0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [127:0] def_line(input logic [31:0] a);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) l[k*32 +: 32] = 32'hC000_0000 | (a + 32'(4 * k));
    return l;
  endfunction

  function automatic logic [127:0] model_line(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return def_line(a);
  endfunction

  // Monitor, scoreboard and backing-memory responder
  always begin
    resp_t r;
    mreq_t m;
    @(negedge clk);
    #1;
    mcyc++;
    mem_is_output_valid = 1'b0;
    if (!reset) rd_pend = 1'b0;
    if (is_output_valid) begin
      last_resp_cyc = mcyc;
      if (resp_q.size() == 0) begin
        chk("unexpected_resp", 1'b1, 1'b0);
      end else begin
        r = resp_q.pop_front();
        chk("is_hit", is_hit, r.hit);
        if (r.chk_dout) chk("dout", dout, r.dout);
      end
    end
    if (mem_is_input_valid) begin
      mem_req_cnt++;
      chk("mem_ready_at_req", mem_ready, 1'b1);
      chk("mem_req_gap", prev_miv, 1'b0);
      if (mreq_q.size() == 0) begin
        chk("unexpected_mem_req", 1'b1, 1'b0);
      end else begin
        m = mreq_q.pop_front();
        chk("mem_type", {mem_read_o, mem_write_o}, m.wr ? 2'b01 : 2'b10);
        chk("mem_addr", mem_addr, m.a);
        if (m.wr) begin
          chk("mem_din", mem_din, m.d);
          mem_model[mem_addr] = mem_din;
        end else begin
          rd_pend = 1'b1;
          rd_cnt  = 2;
          rd_addr = mem_addr;
        end
      end
    end
    prev_miv = mem_is_input_valid;
    if (rd_pend) begin
      if (rd_cnt == 0) begin
        mem_is_output_valid = 1'b1;
        mem_dout = model_line(rd_addr);
        rd_pend = 1'b0;
      end else begin
        rd_cnt--;
      end
    end
    if (stray_req) begin
      mem_is_output_valid = 1'b1;
      mem_dout = {4{32'hBAD0_BAD0}};
      stray_req = 1'b0;
    end
  end

  task automatic issue(input logic [31:0] a, input logic rd, input logic wr, input logic [31:0] d);
    @(negedge clk);
    addr = a; mem_read = rd; mem_write = wr; din = d; is_input_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    acc_cyc = mcyc;
    is_input_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      #2;
      if (resp_q.size() == 0 && is_ready) done = 1'b1;
    end
    chk(tag, done, 1'b1);
  endtask

  task automatic push_resp(input logic cd, input logic [31:0] d, input logic h);
    resp_t r;
    r.chk_dout = cd; r.dout = d; r.hit = h;
    resp_q.push_back(r);
  endtask

  task automatic push_mem(input logic wr, input logic [31:0] a, input logic [127:0] d);
    mreq_t m;
    m.wr = wr; m.a = a; m.d = d;
    mreq_q.push_back(m);
  endtask

  initial begin
    int cnt0;
    reset = 1'b0; is_input_valid = 1'b0; addr = '0; mem_read = 1'b0; mem_write = 1'b0;
    din = '0; mem_ready = 1'b1; mem_is_output_valid = 1'b0; mem_dout = '0;
    mem_model[32'h100] = {32'd4, 32'd3, 32'd2, 32'd1};
    repeat (2) @(negedge clk);
    #1;
    chk("rst_is_ready", is_ready, 1'b1);
    chk("rst_out_valid", is_output_valid, 1'b0);
    chk("rst_dout", dout, 32'd0);
    chk("rst_is_hit", is_hit, 1'b0);
    chk("rst_mem_valid", mem_is_input_valid, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Cold read of 0x100
    push_mem(1'b0, 32'h100, '0);
    push_resp(1'b1, 32'd1, 1'b0);
    issue(32'h100, 1'b1, 1'b0, '0);
    wait_idle("done_cold_read");

    // Read hit of 0x10C with latency check
    push_resp(1'b1, 32'd4, 1'b1);
    issue(32'h10C, 1'b1, 1'b0, '0);
    chk("busy_not_ready", is_ready, 1'b0);
    wait_idle("done_hit_read");
    chk("hit_latency", 32'(last_resp_cyc - acc_cyc), 32'd2);

    // Write hit, no memory traffic, then read back
    cnt0 = mem_req_cnt;
    push_resp(1'b0, '0, 1'b1);
    issue(32'h104, 1'b0, 1'b1, 32'hDEAD_BEEF);
    wait_idle("done_write_hit");
    push_resp(1'b1, 32'hDEAD_BEEF, 1'b1);
    issue(32'h104, 1'b1, 1'b0, '0);
    wait_idle("done_read_written");
    chk("no_mem_on_hits", 32'(mem_req_cnt - cnt0), 32'd0);

    // Fill second way with 0x200 and dirty it
    push_mem(1'b0, 32'h200, '0);
    push_resp(1'b1, 32'hC000_0200, 1'b0);
    issue(32'h200, 1'b1, 1'b0, '0);
    wait_idle("done_read_200");
    push_resp(1'b0, '0, 1'b1);
    issue(32'h204, 1'b0, 1'b1, 32'h1234_5678);
    wait_idle("done_write_204");
    push_resp(1'b1, 32'd1, 1'b1);
    issue(32'h100, 1'b1, 1'b0, '0);
    wait_idle("done_touch_100");

    // 0x300 evicts dirty 0x200: write-back held by mem_ready=0, then refill
    mem_ready = 1'b0;
    push_mem(1'b1, 32'h200, {32'hC000_020C, 32'hC000_0208, 32'h1234_5678, 32'hC000_0200});
    push_mem(1'b0, 32'h300, '0);
    push_resp(1'b1, 32'hC000_0300, 1'b0);
    cnt0 = mem_req_cnt;
    issue(32'h300, 1'b1, 1'b0, '0);
    repeat (6) @(negedge clk);
    chk("wb_held_no_req", 32'(mem_req_cnt - cnt0), 32'd0);
    chk("wb_held_busy", is_ready, 1'b0);
    mem_ready = 1'b1;
    wait_idle("done_evict");
    chk("mem_reqs_consumed", 32'(mreq_q.size()), 32'd0);

    // 0x100 survived the eviction
    push_resp(1'b1, 32'd1, 1'b1);
    issue(32'h100, 1'b1, 1'b0, '0);
    wait_idle("done_100_still_hit");

    // 0x200 comes back from memory with the written-back word
    push_mem(1'b0, 32'h200, '0);
    push_resp(1'b1, 32'h1234_5678, 1'b0);
    issue(32'h204, 1'b1, 1'b0, '0);
    wait_idle("done_reread_204");

    // Reset while stuck in ALLOCATE
    mem_ready = 1'b0;
    issue(32'h410, 1'b1, 1'b0, '0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_is_ready", is_ready, 1'b1);
    chk("midrst_out_valid", is_output_valid, 1'b0);
    chk("midrst_dout", dout, 32'd0);
    chk("midrst_is_hit", is_hit, 1'b0);
    chk("midrst_mem_valid", mem_is_input_valid, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    mem_ready = 1'b1;
    stray_req = 1'b1;
    repeat (4) @(negedge clk);
    #2;
    chk("after_stray_ready", is_ready, 1'b1);

    // Contents were invalidated: 0x100 misses again
    push_mem(1'b0, 32'h100, '0);
    push_resp(1'b1, 32'd1, 1'b0);
    issue(32'h100, 1'b1, 1'b0, '0);
    wait_idle("done_post_reset_miss");

    // Malformed requests are ignored
    cnt0 = mem_req_cnt;
    issue(32'h100, 1'b1, 1'b1, '0);
    #2;
    chk("both_set_ready", is_ready, 1'b1);
    issue(32'h100, 1'b0, 1'b0, '0);
    #2;
    chk("none_set_ready", is_ready, 1'b1);
    repeat (3) @(negedge clk);
    chk("bad_req_no_mem", 32'(mem_req_cnt - cnt0), 32'd0);
    chk("resp_queue_empty", 32'(resp_q.size()), 32'd0);
    chk("mem_queue_empty", 32'(mreq_q.size()), 32'd0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule

// File: doc/set_assoc_cache.md
SET_ASSOC_CACHE -- requirements
Module: set_assoc_cache

Interface
REQ-001 Parameter LINE_SIZE, 16, line size in bytes; power of 2, at least 8.
REQ-002 Parameter NUM_SETS, 16, sets per way; power of 2, at least 2.
REQ-003 Parameter NUM_WAYS, 2, associativity; power of 2, 1 to 8.
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 is_input_valid  in  1  CPU request strobe; accepted only while is_ready=1.
REQ-007 addr  in  32  byte address; the low 2 bits are ignored.
REQ-008 mem_read / mem_write  in  1 each  request type.
REQ-009 din  in  32  write data.
REQ-010 is_ready  out  1  cache idle and able to accept a request.
REQ-011 is_output_valid  out  1  one-cycle completion pulse, for reads and writes.
REQ-012 dout  out  32  read data; meaningful only when is_output_valid=1 for a read.
REQ-013 is_hit  out  1  result of the first tag lookup; meaningful only with is_output_valid.
REQ-014 mem_is_input_valid  out  1  one-cycle backing-memory request strobe.
REQ-015 mem_addr  out  32  line-aligned memory address.
REQ-016 mem_read_o / mem_write_o  out  1 each  memory request type.
REQ-017 mem_din  out  LINE_SIZE*8  victim line for write-back.
REQ-018 mem_is_output_valid  in  1  refill data valid pulse.
REQ-019 mem_dout  in  LINE_SIZE*8  refill line.
REQ-020 mem_ready  in  1  memory able to accept a request.

Function
REQ-021 Address split: offset = addr[CLOG2(LINE_SIZE)-1:0]; word select = offset[..:2]; index = next CLOG2(NUM_SETS) bits; tag = the remaining upper bits.
REQ-022 Each way and set SHALL hold a valid bit, a dirty bit, a tag and one line; the policy is write-back with write-allocate.
REQ-023 FSM states: IDLE, COMPARE, WRITEBACK, ALLOCATE, RESPOND.
REQ-024 IDLE: is_ready=1; a request is accepted when is_input_valid=1 and exactly one of mem_read/mem_write is 1. The cache latches addr, din and type, then goes to COMPARE.
REQ-025 If both or neither of mem_read/mem_write are set, the request SHALL be ignored: stay in IDLE, no pulse.
REQ-026 COMPARE, hit: a read returns the selected word; a write merges din and sets dirty. The way's LRU is updated and the FSM goes to RESPOND with is_hit=1.
REQ-027 Hit latency: accept at edge N, is_output_valid high during cycle N+2, is_ready high again in the following cycle.
REQ-028 COMPARE, miss: the victim is the lowest-index invalid way, else the LRU way. A dirty victim goes to WRITEBACK; otherwise the FSM goes to ALLOCATE.
REQ-029 WRITEBACK: wait for mem_ready=1, then pulse mem_is_input_valid with mem_write_o=1, mem_addr={victim tag, index, 0}, mem_din=victim line. Clear dirty, then go to ALLOCATE.
REQ-030 ALLOCATE: wait for mem_ready=1, then pulse a read of the request's line address. On mem_is_output_valid, write mem_dout into the victim with valid=1, dirty=0 and the new tag, then return to COMPARE.
REQ-031 The re-COMPARE after refill SHALL hit. is_hit reported SHALL remain 0, the first-lookup result.
REQ-032 LRU: per-set age counters of CLOG2(NUM_WAYS) bits. The accessed way is set to 0; ways younger than it increment; the victim is the way with maximum age.
REQ-033 is_ready=0 in every state except IDLE; is_input_valid is ignored while busy.
REQ-034 mem_is_input_valid SHALL never be asserted while mem_ready=0, and never for two consecutive cycles.
REQ-035 dout and is_hit hold their last values between pulses.

Reset
REQ-036 reset=0 SHALL immediately clear all valid, dirty and LRU state, force IDLE, and set is_output_valid, mem_is_input_valid, mem_read_o and mem_write_o to 0, dout=0 and is_hit=0.
REQ-037 A reset during WRITEBACK or ALLOCATE abandons the transaction, and any later mem_is_output_valid is ignored until a new ALLOCATE.
REQ-038 Tag and line storage need no reset.

Structure
REQ-039 Shared package cache_pkg: FSM state encoding, CLOG2 width helpers, word-select macros.
REQ-040 One sub-module, cache_lru: per-set age array with update and victim-select ports, parametrised by NUM_SETS and NUM_WAYS.

Verification (defaults: index=addr[7:4], tag=addr[31:8])
REQ-041 Cold read of 0x100 with mem_dout={W3..W0}={4,3,2,1}: memory read at 0x100, dout=1, is_hit=0. A second read of 0x10C gives dout=4, is_hit=1, with output two cycles after acceptance.
REQ-042 Write 0x104 with din=0xDEADBEEF after the fill: is_hit=1, no memory traffic. A following read of 0x104 returns 0xDEADBEEF with is_hit=1.
REQ-043 Read 0x100, read 0x200, read 0x100, then read 0x300: 0x200's way is evicted, and a later read of 0x100 still hits.
REQ-044 Dirty 0x200 evicted by read 0x300: memory write at 0x200 with the modified line precedes the memory read at 0x300. The write is held while mem_ready=0.
REQ-045 reset low mid-ALLOCATE: is_ready=1 immediately, and read 0x100 afterwards misses.
REQ-046 is_input_valid with mem_read=mem_write=1: no pulse, no memory request, is_ready stays 1.
